mem_port_arbiter: RTL

- Shares one single-ported unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store) of the 5-stage RISC-V pipeline.
- Arbitrates requests, sequences each memory transaction and returns data to the winning requester.
- Drives pipeline_stall to freeze the pipeline while any request is outstanding.
- Guards against a hung memory with a timeout and a sticky error flag.

---
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported unified memory between the IF stage (read-only
// fetch) and the MEM stage (load/store). IDLE arbitrates between the two
// requesters, BUSY holds the registered memory request until port_ack or a
// timeout, and RESP returns a one-cycle ready pulse to the owner.
module mem_port_arbiter #(
    parameter int XLEN          = 32,
    parameter int TIMEOUT       = 16,
    parameter int IF_STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_ready,
    input  logic            mem_req,
    input  logic            mem_we,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_wdata,
    output logic [XLEN-1:0] mem_rdata,
    output logic            mem_ready,
    output logic            port_req,
    output logic            port_we,
    output logic [XLEN-1:0] port_addr,
    output logic [XLEN-1:0] port_wdata,
    input  logic [XLEN-1:0] port_rdata,
    input  logic            port_ack,
    output logic            grant_mem,
    output logic            pipeline_stall,
    output logic            bus_error
);

    // Timeout counter counts BUSY cycles 0 .. TIMEOUT-1; abort happens on the last one.
    localparam int TO_W = $clog2(TIMEOUT);
    localparam int SC_W = $clog2(IF_STARVE_MAX + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [SC_W-1:0] SC_MAX  = SC_W'(IF_STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [TO_W-1:0] to_cnt;
    logic [SC_W-1:0] starve_cnt;

    logic            starve_hit;
    logic            arb_any;
    logic            arb_mem;

    // Starve counter saturates at IF_STARVE_MAX so it never wraps back to 0.
    function automatic logic [SC_W-1:0] starve_sat_inc(input logic [SC_W-1:0] cnt);
        return (cnt == SC_MAX) ? cnt : cnt + 1'b1;
    endfunction

    // Arbitration: MEM has priority unless IF has been passed over IF_STARVE_MAX times.
    always_comb begin
        starve_hit = (starve_cnt == SC_MAX);
        arb_any    = if_req | mem_req;
        arb_mem    = mem_req & ~(if_req & starve_hit);
    end

    // The pipeline is frozen while any requester waits for its completion pulse.
    assign pipeline_stall = (if_req & ~if_ready) | (mem_req & ~mem_ready);

    // Transaction sequencer: grant in IDLE, wait for ack or timeout in BUSY, pulse ready in RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            port_req   <= 1'b0;
            port_we    <= 1'b0;
            port_addr  <= '0;
            port_wdata <= '0;
            grant_mem  <= 1'b0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
            if_ready   <= 1'b0;
            mem_ready  <= 1'b0;
            bus_error  <= 1'b0;
            starve_cnt <= '0;
            to_cnt     <= '0;
        end else begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            case (state)
                IDLE: begin
                    // IF waiting while MEM wins bumps the counter; anything else clears it.
                    if (!if_req) begin
                        starve_cnt <= '0;
                    end else if (arb_mem) begin
                        starve_cnt <= starve_sat_inc(starve_cnt);
                    end else begin
                        starve_cnt <= '0;
                    end

                    if (arb_any) begin
                        port_req  <= 1'b1;
                        grant_mem <= arb_mem;
                        to_cnt    <= '0;
                        state     <= BUSY;
                        if (arb_mem) begin
                            port_we    <= mem_we;
                            port_addr  <= mem_addr;
                            port_wdata <= mem_wdata;
                        end else begin
                            port_we    <= 1'b0;
                            port_addr  <= if_addr;
                            port_wdata <= '0;
                        end
                    end
                end

                BUSY: begin
                    if (port_ack) begin
                        // Stores also return port_rdata unchanged to the MEM side.
                        port_req <= 1'b0;
                        state    <= RESP;
                        if (grant_mem) begin
                            mem_rdata <= port_rdata;
                            mem_ready <= 1'b1;
                        end else begin
                            if_rdata <= port_rdata;
                            if_ready <= 1'b1;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        // Hung memory: abort, hand back zero data and latch the error.
                        port_req  <= 1'b0;
                        bus_error <= 1'b1;
                        state     <= RESP;
                        if (grant_mem) begin
                            mem_rdata <= '0;
                            mem_ready <= 1'b1;
                        end else begin
                            if_rdata <= '0;
                            if_ready <= 1'b1;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                RESP: begin
                    // Requests are not sampled here so the requester can change or drop req.
                    state <= IDLE;
                end

                default: begin
                    port_req <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
